// File: rtl/id_ex_skid_stage_if.sv
// Decode-to-execute bundle bus: decode-side valid/ready plus the registered
// execute-side bundle, grouped so the stage and its neighbours share one port.
interface id_ex_skid_stage_if #(
  parameter int MAX_LENGTH = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CTRL_W     = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [MAX_LENGTH-1:0] in_pc;
  logic [MAX_LENGTH-1:0] in_opa;
  logic [MAX_LENGTH-1:0] in_opb;
  logic [REG_ADDR_W-1:0] in_dst;
  logic [CTRL_W-1:0]     in_ctrl;

  logic                  out_valid;
  logic                  out_ready;
  logic [MAX_LENGTH-1:0] out_pc;
  logic [MAX_LENGTH-1:0] out_opa;
  logic [MAX_LENGTH-1:0] out_opb;
  logic [REG_ADDR_W-1:0] out_dst;
  logic [CTRL_W-1:0]     out_ctrl;

  // Master drives decode bundles and consumes execute bundles.
  modport master (
    output in_valid, in_pc, in_opa, in_opb, in_dst, in_ctrl, out_ready,
    input  in_ready, out_valid, out_pc, out_opa, out_opb, out_dst, out_ctrl
  );

  modport slave (
    input  in_valid, in_pc, in_opa, in_opb, in_dst, in_ctrl, out_ready,
    output in_ready, out_valid, out_pc, out_opa, out_opb, out_dst, out_ctrl
  );
endinterface

// File: rtl/id_ex_skid_stage.sv
// Two-entry skid-buffered ID/EX pipeline register with flush and a saturating
// execute back-pressure counter; in_ready is a flop so decode never sees a
// combinational path from the execute stall.
module id_ex_skid_stage #(
  parameter int MAX_LENGTH = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CTRL_W     = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  id_ex_skid_stage_if.slave bus,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [MAX_LENGTH-1:0] pc;
    logic [MAX_LENGTH-1:0] opa;
    logic [MAX_LENGTH-1:0] opb;
    logic [REG_ADDR_W-1:0] dst;
    logic [CTRL_W-1:0]     ctrl;
  } bundle_t;

  localparam logic [CNT_W-1:0] STALL_MAX = '1;
  localparam logic [CNT_W-1:0] STALL_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic             inReady_q, inReady_d;
  bundle_t          main_q, main_d;
  bundle_t          skid_q, skid_d;
  logic [CNT_W-1:0] stallCount_q, stallCount_d;

  bundle_t inBundle;
  logic    outValid;
  logic    accept;
  logic    drain;

  assign inBundle = '{pc:   bus.in_pc,
                      opa:  bus.in_opa,
                      opb:  bus.in_opb,
                      dst:  bus.in_dst,
                      ctrl: bus.in_ctrl};

  assign outValid = (state_q != EMPTY);
  assign accept   = bus.in_valid && inReady_q;
  assign drain    = outValid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= EMPTY;
      inReady_q    <= 1'b1;
      main_q       <= '0;
      skid_q       <= '0;
      stallCount_q <= '0;
    end else begin
      state_q      <= state_d;
      inReady_q    <= inReady_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
      stallCount_q <= stallCount_d;
    end
  end

  // Flush suppresses every slot load, so held data fields keep their values.
  always_comb begin
    state_d      = state_q;
    main_d       = main_q;
    skid_d       = skid_q;
    stallCount_d = stallCount_q;

    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            main_d  = inBundle;
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (accept && !drain) begin
            skid_d  = inBundle;
            state_d = FULL;
          end else if (accept && drain) begin
            main_d  = inBundle;
          end else if (drain) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (drain) begin
            main_d  = skid_q;
            state_d = BUSY;
          end
        end
        default: state_d = EMPTY;
      endcase

      if (outValid && !bus.out_ready && (stallCount_q != STALL_MAX)) begin
        stallCount_d = stallCount_q + STALL_ONE;
      end
    end

    inReady_d = (state_d != FULL);
  end

  assign bus.in_ready  = inReady_q;
  assign bus.out_valid = outValid;
  assign bus.out_pc    = main_q.pc;
  assign bus.out_opa   = main_q.opa;
  assign bus.out_opb   = main_q.opb;
  assign bus.out_dst   = main_q.dst;
  assign bus.out_ctrl  = main_q.ctrl;
  assign stall_count   = stallCount_q;

endmodule

// File: tb/tb_id_ex_skid_stage.sv
// Directed self-checking bench for id_ex_skid_stage: a 16-bit-counter instance
// for the data path and a 4-bit-counter instance for saturation.
module tb_id_ex_skid_stage;

  logic clk;
  logic reset;
  logic flush;
  logic [15:0] stallCount;
  logic [3:0]  stallCountSat;

  int assertCount = 0;
  int failCount   = 0;

  id_ex_skid_stage_if #(.MAX_LENGTH(32), .REG_ADDR_W(5), .CTRL_W(8)) bus ();
  id_ex_skid_stage_if #(.MAX_LENGTH(32), .REG_ADDR_W(5), .CTRL_W(8)) busSat ();

  id_ex_skid_stage #(.MAX_LENGTH(32), .REG_ADDR_W(5), .CTRL_W(8), .CNT_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .bus         (bus),
    .stall_count (stallCount)
  );

  id_ex_skid_stage #(.MAX_LENGTH(32), .REG_ADDR_W(5), .CTRL_W(8), .CNT_W(4)) dutSat (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .bus         (busSat),
    .stall_count (stallCountSat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single checking point: counts the comparison and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one edge and settle 1 time unit past it before checking or driving.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] pc,
                               input logic [31:0] opa, input logic [31:0] opb,
                               input logic [4:0] dst, input logic [7:0] ctrl);
    bus.in_valid = valid;
    bus.in_pc    = pc;
    bus.in_opa   = opa;
    bus.in_opb   = opb;
    bus.in_dst   = dst;
    bus.in_ctrl  = ctrl;
  endtask

  task automatic resetDut();
    reset = 1'b1;
    stepCycle();
    stepCycle();
    reset = 1'b0;
  endtask

  initial begin
    flush            = 1'b0;
    bus.out_ready    = 1'b0;
    busSat.out_ready = 1'b0;
    busSat.in_valid  = 1'b0;
    busSat.in_pc     = '0;
    busSat.in_opa    = '0;
    busSat.in_opb    = '0;
    busSat.in_dst    = '0;
    busSat.in_ctrl   = '0;
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 8'h0);

    // Reset then idle
    resetDut();
    checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst_in_ready",  64'(bus.in_ready),  64'd1);
    checkOutput("rst_out_pc",    64'(bus.out_pc),    64'd0);
    checkOutput("rst_stall",     64'(stallCount),    64'd0);

    // Single pass
    bus.out_ready = 1'b1;
    applyStimulus(1'b1, 32'h100, 32'd5, 32'd7, 5'd3, 8'h21);
    stepCycle();
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 8'h0);
    checkOutput("single_valid", 64'(bus.out_valid), 64'd1);
    checkOutput("single_pc",    64'(bus.out_pc),    64'h100);
    checkOutput("single_opa",   64'(bus.out_opa),   64'd5);
    checkOutput("single_opb",   64'(bus.out_opb),   64'd7);
    checkOutput("single_dst",   64'(bus.out_dst),   64'd3);
    checkOutput("single_ctrl",  64'(bus.out_ctrl),  64'h21);
    stepCycle();
    checkOutput("single_empty", 64'(bus.out_valid), 64'd0);

    // Back-pressure fill: two accepted, third held upstream
    resetDut();
    bus.out_ready = 1'b0;
    applyStimulus(1'b1, 32'h100, 32'd1, 32'd2, 5'd1, 8'h01);
    stepCycle();
    checkOutput("bp_ready_busy", 64'(bus.in_ready), 64'd1);
    applyStimulus(1'b1, 32'h104, 32'd3, 32'd4, 5'd2, 8'h02);
    stepCycle();
    checkOutput("bp_ready_full", 64'(bus.in_ready), 64'd0);
    checkOutput("bp_head_pc",    64'(bus.out_pc),   64'h100);
    applyStimulus(1'b1, 32'h108, 32'd5, 32'd6, 5'd3, 8'h03);
    stepCycle();
    checkOutput("bp_hold_ready", 64'(bus.in_ready), 64'd0);
    checkOutput("bp_hold_pc",    64'(bus.out_pc),   64'h100);
    checkOutput("bp_stall",      64'(stallCount),   64'd2);
    bus.out_ready = 1'b1;
    stepCycle();
    checkOutput("bp_out1_pc",    64'(bus.out_pc),    64'h104);
    checkOutput("bp_out1_opa",   64'(bus.out_opa),   64'd3);
    checkOutput("bp_out1_valid", 64'(bus.out_valid), 64'd1);
    checkOutput("bp_reopen",     64'(bus.in_ready),  64'd1);
    stepCycle();
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 8'h0);
    checkOutput("bp_out2_pc",    64'(bus.out_pc),    64'h108);
    checkOutput("bp_out2_ctrl",  64'(bus.out_ctrl),  64'h03);
    stepCycle();
    checkOutput("bp_drained",    64'(bus.out_valid), 64'd0);
    checkOutput("bp_stall_end",  64'(stallCount),    64'd2);

    // Full throughput: one bundle per cycle, no back-pressure
    resetDut();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 32'h300 + 32'(4 * i), 32'(i), 32'(i + 100), 5'(i), 8'(i));
      stepCycle();
      checkOutput("tput_pc",    64'(bus.out_pc),    64'(32'h300 + 32'(4 * i)));
      checkOutput("tput_opb",   64'(bus.out_opb),   64'(i + 100));
      checkOutput("tput_ready", 64'(bus.in_ready),  64'd1);
      checkOutput("tput_valid", 64'(bus.out_valid), 64'd1);
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 8'h0);
    stepCycle();
    checkOutput("tput_empty", 64'(bus.out_valid), 64'd0);
    checkOutput("tput_stall", 64'(stallCount),    64'd0);

    // Flush while FULL, with a same-cycle bundle that must be dropped
    resetDut();
    bus.out_ready = 1'b0;
    applyStimulus(1'b1, 32'h200, 32'd0, 32'd0, 5'd0, 8'h0);
    stepCycle();
    applyStimulus(1'b1, 32'h204, 32'd0, 32'd0, 5'd0, 8'h0);
    stepCycle();
    checkOutput("fl_full", 64'(bus.in_ready), 64'd0);
    applyStimulus(1'b1, 32'h208, 32'd0, 32'd0, 5'd0, 8'h0);
    flush = 1'b1;
    stepCycle();
    flush = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 8'h0);
    checkOutput("fl_valid",   64'(bus.out_valid), 64'd0);
    checkOutput("fl_ready",   64'(bus.in_ready),  64'd1);
    checkOutput("fl_data",    64'(bus.out_pc),    64'h200);
    checkOutput("fl_stall",   64'(stallCount),    64'd1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checkOutput("fl_no_out", 64'(bus.out_valid), 64'd0);
    end

    // Saturation on the 4-bit counter instance, then reset clears it
    busSat.in_valid = 1'b1;
    busSat.in_pc    = 32'h400;
    stepCycle();
    busSat.in_valid = 1'b0;
    checkOutput("sat_valid", 64'(busSat.out_valid), 64'd1);
    checkOutput("sat_start", 64'(stallCountSat),    64'd0);
    for (int i = 0; i < 10; i++) stepCycle();
    checkOutput("sat_mid",   64'(stallCountSat),    64'd10);
    for (int i = 0; i < 10; i++) stepCycle();
    checkOutput("sat_max",   64'(stallCountSat),    64'd15);
    checkOutput("sat_hold",  64'(busSat.out_pc),    64'h400);
    resetDut();
    checkOutput("sat_reset", 64'(stallCountSat),    64'd0);
    checkOutput("sat_empty", 64'(busSat.out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
